// File: rtl/parking_pkg.sv
// Shared state encoding, LED decode table and sizing helper for the
// parking gate controller.
package parking_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_PW = 3'd1,
      WRONG   = 3'd2,
      GRANT   = 3'd3,
      STOP    = 3'd4,
      LOCKED  = 3'd5
   } state_t;

   typedef struct packed {
      logic gate_open;
      logic led_wait;
      logic led_alert;
      logic led_available;
      logic lockout;
   } led_t;

   localparam led_t LED_IDLE   = 5'b00000;
   localparam led_t LED_WAIT   = 5'b01000;
   localparam led_t LED_WRONG  = 5'b01100;
   localparam led_t LED_GRANT  = 5'b10010;
   localparam led_t LED_STOP   = 5'b01100;
   localparam led_t LED_LOCKED = 5'b00101;

   function automatic led_t led_decode(input state_t s);
      case (s)
         WAIT_PW: return LED_WAIT;
         WRONG:   return LED_WRONG;
         GRANT:   return LED_GRANT;
         STOP:    return LED_STOP;
         LOCKED:  return LED_LOCKED;
         default: return LED_IDLE;
      endcase
   endfunction

   function automatic int occ_width(input int cap);
      return $clog2(cap + 1);
   endfunction

endpackage

// File: rtl/parking_occupancy_cnt.sv
// Saturating up/down car counter; full is registered from the next count
// so it lines up with occupancy.
module parking_occupancy_cnt import parking_pkg::*; #(
   parameter int CAPACITY = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               inc,
   input  logic                               dec,
   output logic [occ_width(CAPACITY)-1:0]     occupancy,
   output logic                               full
);

   localparam int OW = occ_width(CAPACITY);
   localparam logic [OW-1:0] CAP = OW'(CAPACITY);

   logic [OW-1:0] occ_next;

   // A simultaneous arrival and departure cancel out.
   always_comb begin
      occ_next = occupancy;
      if (inc && !dec) begin
         if (occupancy < CAP) occ_next = occupancy + OW'(1);
      end else if (dec && !inc) begin
         if (occupancy != '0) occ_next = occupancy - OW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occupancy <= '0;
         full      <= 1'b0;
      end else begin
         occupancy <= occ_next;
         full      <= (occ_next == CAP);
      end
   end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Car-park entry controller: password FSM with retry/lockout, timeout,
// tailgate detection and occupancy tracking.
module parking_gate_ctrl import parking_pkg::*; #(
   parameter int                  PW_WIDTH    = 4,
   parameter logic [PW_WIDTH-1:0] PASSWORD    = 4'b1011,
   parameter int                  MAX_TRIES   = 3,
   parameter int                  CAPACITY    = 8,
   parameter int                  TIMEOUT_CYC = 16,
   parameter int                  LOCK_CYC    = 32
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           sensor_entrance,
   input  logic                           sensor_exit,
   input  logic                           car_leave,
   input  logic                           pw_valid,
   input  logic [PW_WIDTH-1:0]            pw_data,
   output logic                           gate_open,
   output logic                           led_wait,
   output logic                           led_alert,
   output logic                           led_available,
   output logic                           led_full,
   output logic                           lockout,
   output logic [occ_width(CAPACITY)-1:0] occupancy
);

   localparam int TRY_W = $clog2(MAX_TRIES + 1);
   localparam int TMAX  = (TIMEOUT_CYC > LOCK_CYC) ? TIMEOUT_CYC : LOCK_CYC;
   localparam int TIM_W = $clog2(TMAX);
   localparam int OW    = occ_width(CAPACITY);
   localparam logic [TRY_W-1:0] TRY_LAST  = TRY_W'(MAX_TRIES);
   localparam logic [TIM_W-1:0] TO_LAST   = TIM_W'(TIMEOUT_CYC - 1);
   localparam logic [TIM_W-1:0] LOCK_LAST = TIM_W'(LOCK_CYC - 1);
   localparam logic [OW-1:0]    CAP       = OW'(CAPACITY);

   state_t           state, state_next;
   logic [TRY_W-1:0] tries, tries_next, tries_inc;
   logic [TIM_W-1:0] timer, timer_next;
   logic             pw_ok, has_room, occ_inc;
   led_t             leds;

   // One timer serves both the password timeout and the lockout period.
   always_comb begin
      state_next = state;
      tries_next = tries;
      timer_next = timer;
      occ_inc    = 1'b0;
      tries_inc  = tries + TRY_W'(1);
      pw_ok      = (pw_data == PASSWORD);
      has_room   = (occupancy < CAP);
      case (state)
         IDLE: begin
            if (sensor_entrance && has_room) begin
               state_next = WAIT_PW;
               tries_next = '0;
               timer_next = '0;
            end
         end
         WAIT_PW, WRONG: begin
            if (pw_valid) begin
               timer_next = '0;
               if (pw_ok) begin
                  state_next = GRANT;
               end else begin
                  tries_next = tries_inc;
                  state_next = (tries_inc == TRY_LAST) ? LOCKED : WRONG;
               end
            end else if (timer == TO_LAST) begin
               state_next = IDLE;
            end else begin
               timer_next = timer + TIM_W'(1);
            end
         end
         GRANT: begin
            if (sensor_exit) begin
               occ_inc    = 1'b1;
               state_next = sensor_entrance ? STOP : IDLE;
            end
         end
         STOP: begin
            if (pw_valid) begin
               if (pw_ok) begin
                  state_next = has_room ? GRANT : IDLE;
               end else begin
                  tries_next = tries_inc;
                  if (tries_inc == TRY_LAST) begin
                     state_next = LOCKED;
                     timer_next = '0;
                  end
               end
            end else if (!sensor_entrance) begin
               state_next = IDLE;
            end
         end
         LOCKED: begin
            if (timer == LOCK_LAST) begin
               state_next = IDLE;
               tries_next = '0;
            end else begin
               timer_next = timer + TIM_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs decode next_state so they change on the same edge as the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         tries <= '0;
         timer <= '0;
         leds  <= LED_IDLE;
      end else begin
         state <= state_next;
         tries <= tries_next;
         timer <= timer_next;
         leds  <= led_decode(state_next);
      end
   end

   assign gate_open     = leds.gate_open;
   assign led_wait      = leds.led_wait;
   assign led_alert     = leds.led_alert;
   assign led_available = leds.led_available;
   assign lockout       = leds.lockout;

   parking_occupancy_cnt #(
      .CAPACITY (CAPACITY)
   ) u_occ (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (occ_inc),
      .dec       (car_leave),
      .occupancy (occupancy),
      .full      (led_full)
   );

endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
Parametrised car-park entry controller. It handles a multi-bit password with a limited retry count, a password timeout, lockout after too many failures, tailgate detection, and an occupancy counter with a capacity limit.
It sits between the entrance/exit sensors and keypad on one side, and the gate actuator and status LEDs on the other.
Multi-gate builds instantiate it once per entrance.

Parameters:
PW_WIDTH, 4, width of the password word.
PASSWORD, 4'b1011, expected password (PW_WIDTH bits).
MAX_TRIES, 3, wrong attempts allowed before lockout (>=1).
CAPACITY, 8, maximum parked cars (>=1).
TIMEOUT_CYC, 16, idle cycles without pw_valid before the request is abandoned (>=2).
LOCK_CYC, 32, cycles spent in lockout (>=2).

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
sensor_entrance  in  1  car present at the entrance.
sensor_exit  in  1  car has passed the gate (inner sensor).
car_leave  in  1  one-cycle pulse: a car left the park.
pw_valid  in  1  pw_data is valid this cycle (one attempt per pulse).
pw_data  in  PW_WIDTH  entered password.
gate_open  out  1  gate actuator.
led_wait  out  1  waiting for password.
led_alert  out  1  wrong password, tailgate or lockout.
led_available  out  1  access granted.
led_full  out  1  occupancy == CAPACITY.
lockout  out  1  in lockout.
occupancy  out  $clog2(CAPACITY+1)  cars currently inside.

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; tries=0; timer=0; occupancy=0.
  - All outputs 0.
- Output timing:
  - All outputs are registered.
  - LED/gate/lockout outputs are decoded from next_state, so they align with the state on the same clock edge (no extra cycle of lag).
  - led_full is registered from the next occupancy value.
- State decode:
  - IDLE: all LEDs 0.
  - WAIT_PW: led_wait.
  - WRONG: led_alert, led_wait.
  - GRANT: led_available, gate_open.
  - STOP: led_alert, led_wait.
  - LOCKED: led_alert, lockout.
- IDLE:
  - sensor_entrance=1 && occupancy<CAPACITY -> WAIT_PW; tries:=0; timer:=0.
  - When full, stay in IDLE.
- WAIT_PW / WRONG:
  - pw_valid && pw_data==PASSWORD -> GRANT.
  - pw_valid && mismatch -> tries+1. If the new tries==MAX_TRIES -> LOCKED, else WRONG.
  - Any pw_valid clears timer.
  - No pw_valid -> timer+1. When timer reaches TIMEOUT_CYC-1 with no pw_valid -> IDLE.
- GRANT:
  - sensor_exit && !sensor_entrance -> IDLE; occupancy+1.
  - sensor_exit && sensor_entrance -> STOP (tailgate); occupancy+1.
  - Otherwise hold in GRANT (no timeout).
- STOP:
  - pw_valid correct -> GRANT, only if occupancy<CAPACITY; else -> IDLE.
  - pw_valid wrong -> tries+1; LOCKED at MAX_TRIES, else stay in STOP.
  - !sensor_entrance && no pw_valid -> IDLE (tailgater backed out).
- LOCKED:
  - Counter runs LOCK_CYC cycles, then -> IDLE with tries:=0.
  - Sensors and pw_valid are ignored while locked.
- Occupancy:
  - Increment and car_leave in the same cycle -> unchanged.
  - car_leave at 0 -> ignored (no underflow).
  - Increment saturates at CAPACITY (no wrap).
  - car_leave is honoured in every state, including LOCKED.
- Illegal state encoding -> IDLE next cycle.
- rst_n asserted mid-operation -> immediate return to reset values; occupancy is lost by design.

Decomposition:
- Package parking_pkg holds:
  - state enum (IDLE, WAIT_PW, WRONG, GRANT, STOP, LOCKED), 3-bit encoding;
  - LED decode constants;
  - an occupancy-width function.
- One natural sub-module, parking_occupancy_cnt: saturating up/down counter with CAPACITY, producing occupancy and full.
- FSM, try counter and timer stay in the top module.

Test Plan:
1. Reset, then entrance=1 for 1 cycle, then pw_valid with 4'b1011, then exit=1/entrance=0 -> states WAIT_PW, GRANT, IDLE; gate_open high only in GRANT; occupancy=1.
2. Three wrong passwords (4'b0000) -> WRONG, WRONG, LOCKED. lockout=1 for exactly 32 cycles; a pw_valid during lockout is ignored; then IDLE.
3. Enter WAIT_PW, no pw_valid for 16 cycles -> IDLE on cycle 16, led_wait drops. A pw_valid at cycle 10 restarts the count.
4. GRANT with exit=1 and entrance=1 -> STOP, occupancy+1, alert+wait. Correct password -> GRANT; exit alone -> IDLE; occupancy=2.
5. Fill to 8 cars -> led_full=1; entrance=1 keeps IDLE. car_leave pulse -> occupancy=7, full=0, next entrance accepted. Increment coinciding with car_leave leaves occupancy unchanged.
6. Assert rst_n low while in GRANT with occupancy=3 -> all outputs 0 and occupancy=0 immediately, without waiting for a clock edge.
